// File: rtl/vga_timing_gen_if.sv
// VGA raster bundle: colour-mapper handshake plus DAC-side timing and pixel outputs.
// master = timing generator, slave = colour mapper / DAC / game logic.
// Pure wiring, no state.
interface vga_timing_gen_if;
  logic [7:0] Red_in;
  logic [7:0] Green_in;
  logic [7:0] Blue_in;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pixel_ce;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  Red_in, Green_in, Blue_in,
    output DrawX, DrawY, pixel_ce, frame_start, VGA_CLK,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output Red_in, Green_in, Blue_in,
    input  DrawX, DrawY, pixel_ce, frame_start, VGA_CLK,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides Clk to the pixel rate, scans DrawX/DrawY, registers sync/blank/RGB.
// Latency: RGB/HS/VS/BLANK are loaded on pixel_ce from the current counters, one pixel behind DrawX/DrawY.
// No backpressure: free-running; the colour mapper must settle within CLK_DIV Clk cycles.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  vga_timing_gen_if.master  vga_if
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          vga_clk_q, vga_clk_d;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    g_q, g_d;
  logic [7:0]    b_q, b_d;

  logic pixel_ce;
  logic line_end;
  logic frame_end;
  logic visible;

  // Divider: pixel_ce on the last Clk of each pixel; VGA_CLK is high in the second half so
  // outputs (changing at the end of the pixel) are stable at its rising edge.
  always_comb begin
    pixel_ce  = (div_q == DIV_LAST);
    div_d     = pixel_ce ? '0 : div_q + DW'(1);
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Raster counters: advance one pixel per pixel_ce, wrapping line then frame.
  always_comb begin
    line_end  = (hc_q == H_LAST);
    frame_end = line_end && (vc_q == V_LAST);
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (pixel_ce) begin
      if (line_end) begin
        hc_d = '0;
        vc_d = frame_end ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Output stage: sample sync/blank and the mapper's colour for the pixel currently shown.
  always_comb begin
    visible   = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (pixel_ce) begin
      hs_d      = !((hc_q >= HS_START) && (hc_q < HS_END));
      vs_d      = !((vc_q >= VS_START) && (vc_q < VS_END));
      blank_n_d = visible;
      r_d       = visible ? vga_if.Red_in   : 8'h00;
      g_d       = visible ? vga_if.Green_in : 8'h00;
      b_d       = visible ? vga_if.Blue_in  : 8'h00;
    end
  end

  // State registers with synchronous active-low reset; a mid-frame reset restarts cleanly.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign vga_if.DrawX       = hc_q;
  assign vga_if.DrawY       = vc_q;
  assign vga_if.pixel_ce    = pixel_ce;
  assign vga_if.frame_start = pixel_ce && frame_end;
  assign vga_if.VGA_CLK     = vga_clk_q;
  assign vga_if.VGA_HS      = hs_q;
  assign vga_if.VGA_VS      = vs_q;
  assign vga_if.VGA_BLANK_N = blank_n_q;
  assign vga_if.VGA_SYNC_N  = 1'b0;
  assign vga_if.VGA_R       = r_q;
  assign vga_if.VGA_G       = g_q;
  assign vga_if.VGA_B       = b_q;

endmodule
